// File: rtl/layer_pkg.sv
// Shared types and defaults for the multi-layer pixel->ROM address pipeline.
//   layer_cfg_t : one layer's configuration (enable, offsets, magnification shift, mirror)
//   sel_w()     : width of an index selecting one of n items (never below 1)
package layer_pkg;

  localparam int unsigned NLAYER_DEF   = 4;
  localparam int unsigned HWIDTH_DEF   = 12;
  localparam int unsigned VWIDTH_DEF   = 12;
  localparam int unsigned MAXSHIFT_DEF = 3;

  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned SHW_DEF  = sel_w(MAXSHIFT_DEF + 1);
  localparam int unsigned SELW_DEF = sel_w(NLAYER_DEF);

  typedef struct packed {
    logic                         en;
    logic signed [HWIDTH_DEF-1:0] hoff;
    logic signed [VWIDTH_DEF-1:0] voff;
    logic [SHW_DEF-1:0]           shift;
    logic                         mirror;
  } layer_cfg_t;

endpackage

// File: rtl/layer_addr_pipe_if.sv
// Bus bundle for layer_addr_pipe: config write port, frame commit strobe, coordinate input
// stream (valid/ready) and per-layer address result stream (valid/ready).
//   master : producer of coordinates/config and consumer of results (timing gen + mixer side)
//   slave  : the address pipeline itself
interface layer_addr_pipe_if
  import layer_pkg::*;
#(
  parameter int unsigned NLAYER = NLAYER_DEF,
  parameter int unsigned HWIDTH = HWIDTH_DEF,
  parameter int unsigned VWIDTH = VWIDTH_DEF,
  parameter int unsigned AWIDTH = 15,
  parameter int unsigned SHW    = SHW_DEF,
  parameter int unsigned SELW   = SELW_DEF
);

  logic                           frame_start;
  logic                           cfg_we;
  logic [SELW-1:0]                cfg_layer;
  logic                           cfg_en;
  logic signed [HWIDTH-1:0]       cfg_hoff;
  logic signed [VWIDTH-1:0]       cfg_voff;
  logic [SHW-1:0]                 cfg_shift;
  logic                           cfg_mirror;

  logic                           in_valid;
  logic                           in_ready;
  logic [HWIDTH-1:0]              hdata;
  logic [VWIDTH-1:0]              vdata;

  logic                           out_valid;
  logic                           out_ready;
  logic [NLAYER-1:0][AWIDTH-1:0]  out_addr;
  logic [NLAYER-1:0]              out_hit;
  logic                           out_any;
  logic [SELW-1:0]                out_sel;

  modport master (
    output frame_start, cfg_we, cfg_layer, cfg_en, cfg_hoff, cfg_voff, cfg_shift, cfg_mirror,
    output in_valid, hdata, vdata, out_ready,
    input  in_ready, out_valid, out_addr, out_hit, out_any, out_sel
  );

  modport slave (
    input  frame_start, cfg_we, cfg_layer, cfg_en, cfg_hoff, cfg_voff, cfg_shift, cfg_mirror,
    input  in_valid, hdata, vdata, out_ready,
    output in_ready, out_valid, out_addr, out_hit, out_any, out_sel
  );

endinterface

// File: rtl/layer_xform.sv
// One layer's two-stage coordinate transform.
//   S1: add signed offsets, flag negative sums, divide by 2**shift.
//   S2: bounds check, optional horizontal mirror, row-major ROM address (0 on miss).
// Ports:
//   clk, rst_n  clock / async active-low reset
//   i_s1_load   capture a new coordinate into S1 (uses i_cfg as it is this cycle)
//   i_s2_load   move S1 contents into S2
//   i_cfg       active configuration of this layer
//   i_hdata     pixel column, i_vdata pixel row
//   o_addr      ROM address held in S2, o_hit in-bounds and enabled
module layer_xform
  import layer_pkg::*;
#(
  parameter int unsigned HWIDTH   = HWIDTH_DEF,
  parameter int unsigned VWIDTH   = VWIDTH_DEF,
  parameter int unsigned IMG_W    = 160,
  parameter int unsigned IMG_H    = 120,
  parameter int unsigned AWIDTH   = 15,
  parameter int unsigned MAXSHIFT = MAXSHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_s1_load,
  input  logic              i_s2_load,
  input  layer_cfg_t        i_cfg,
  input  logic [HWIDTH-1:0] i_hdata,
  input  logic [VWIDTH-1:0] i_vdata,
  output logic [AWIDTH-1:0] o_addr,
  output logic              o_hit
);

  localparam int unsigned SHW = sel_w(MAXSHIFT + 1);
  localparam logic [SHW-1:0]    MaxShift = SHW'(MAXSHIFT);
  localparam logic [HWIDTH:0]   TxLim    = (HWIDTH + 1)'(IMG_W);
  localparam logic [HWIDTH:0]   TxMax    = (HWIDTH + 1)'(IMG_W - 1);
  localparam logic [VWIDTH:0]   TyLim    = (VWIDTH + 1)'(IMG_H);
  localparam logic [AWIDTH-1:0] ImgWA    = AWIDTH'(IMG_W);

  // Sums carry two extra bits: unsigned pixel plus signed offset can exceed the
  // positive range of a single extra bit, and must never alias to "negative".
  logic [HWIDTH+1:0] w_sh;
  logic [VWIDTH+1:0] w_sv;
  logic [SHW-1:0]    w_shift;
  logic              w_neg;
  logic [HWIDTH:0]   w_tx;
  logic [VWIDTH:0]   w_ty;

  always_comb begin
    w_sh = {2'b00, i_hdata} + {{2{i_cfg.hoff[HWIDTH-1]}}, i_cfg.hoff};
    w_sv = {2'b00, i_vdata} + {{2{i_cfg.voff[VWIDTH-1]}}, i_cfg.voff};
    // Saturate: anything not in 0..MAXSHIFT-1 becomes MAXSHIFT.
    w_shift = MaxShift;
    for (int unsigned s = 0; s < MAXSHIFT; s++) begin
      if (i_cfg.shift == SHW'(s)) w_shift = SHW'(s);
    end
    w_neg = w_sh[HWIDTH+1] | w_sv[VWIDTH+1];
    w_tx  = w_sh[HWIDTH:0] >> w_shift;
    w_ty  = w_sv[VWIDTH:0] >> w_shift;
  end

  logic            r_en, r_mirror, r_neg;
  logic [HWIDTH:0] r_tx;
  logic [VWIDTH:0] r_ty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_mirror <= 1'b0;
      r_neg    <= 1'b0;
      r_tx     <= '0;
      r_ty     <= '0;
    end else if (i_s1_load) begin
      r_en     <= i_cfg.en;
      r_mirror <= i_cfg.mirror;
      r_neg    <= w_neg;
      r_tx     <= w_tx;
      r_ty     <= w_ty;
    end
  end

  logic              w_hit;
  logic [HWIDTH:0]   w_txm;
  logic [AWIDTH-1:0] w_addr;

  always_comb begin
    w_hit  = r_en & ~r_neg & (r_tx < TxLim) & (r_ty < TyLim);
    w_txm  = r_mirror ? (TxMax - r_tx) : r_tx;
    w_addr = AWIDTH'(r_ty) * ImgWA + AWIDTH'(w_txm);
  end

  logic [AWIDTH-1:0] r_addr;
  logic              r_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_hit  <= 1'b0;
    end else if (i_s2_load) begin
      r_addr <= w_hit ? w_addr : '0;
      r_hit  <= w_hit;
    end
  end

  assign o_addr = r_addr;
  assign o_hit  = r_hit;

endmodule

// File: rtl/layer_addr_pipe.sv
// Pipelined multi-layer pixel -> ROM address transform.
// Each coordinate accepted on io_bus (in_valid/in_ready) yields, two cycles later, one ROM
// address per layer plus hit flags and a front-most-hit select (out_valid/out_ready).
// Config writes land in a shadow copy; frame_start commits all shadows to the active set
// so a frame never renders with half-updated parameters.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   io_bus      layer_addr_pipe_if slave: config, coordinate stream, result stream
module layer_addr_pipe
  import layer_pkg::*;
#(
  parameter int unsigned NLAYER   = NLAYER_DEF,
  parameter int unsigned HWIDTH   = HWIDTH_DEF,
  parameter int unsigned VWIDTH   = VWIDTH_DEF,
  parameter int unsigned IMG_W    = 160,
  parameter int unsigned IMG_H    = 120,
  parameter int unsigned AWIDTH   = 15,
  parameter int unsigned MAXSHIFT = MAXSHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  layer_addr_pipe_if.slave  io_bus
);

  localparam int unsigned SelW = sel_w(NLAYER);

  // Config: shadow written by cfg_we, active updated only by frame_start. A coincident
  // write and commit commits the pre-write shadow (non-blocking read of old value).
  layer_cfg_t r_shadow [NLAYER];
  layer_cfg_t r_active [NLAYER];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NLAYER); i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (io_bus.cfg_we) begin
        r_shadow[io_bus.cfg_layer] <= '{en:     io_bus.cfg_en,
                                        hoff:   io_bus.cfg_hoff,
                                        voff:   io_bus.cfg_voff,
                                        shift:  io_bus.cfg_shift,
                                        mirror: io_bus.cfg_mirror};
      end
      if (io_bus.frame_start) begin
        for (int i = 0; i < int'(NLAYER); i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  // Stage control. in_ready depends only on state and out_ready, never on in_valid.
  logic r_s1_valid, r_s2_valid;
  logic w_s1_adv, w_s2_adv;

  always_comb begin
    w_s2_adv        = r_s1_valid & (~r_s2_valid | io_bus.out_ready);
    io_bus.in_ready = ~r_s1_valid | w_s2_adv;
    w_s1_adv        = io_bus.in_valid & io_bus.in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv)      r_s1_valid <= 1'b1;
      else if (w_s2_adv) r_s1_valid <= 1'b0;
      if (w_s2_adv)              r_s2_valid <= 1'b1;
      else if (io_bus.out_ready) r_s2_valid <= 1'b0;
    end
  end

  logic [NLAYER-1:0][AWIDTH-1:0] w_addr;
  logic [NLAYER-1:0]             w_hit;

  for (genvar g = 0; g < int'(NLAYER); g++) begin : g_layer
    layer_xform #(
      .HWIDTH   (HWIDTH),
      .VWIDTH   (VWIDTH),
      .IMG_W    (IMG_W),
      .IMG_H    (IMG_H),
      .AWIDTH   (AWIDTH),
      .MAXSHIFT (MAXSHIFT)
    ) u_xform (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_s1_load (w_s1_adv),
      .i_s2_load (w_s2_adv),
      .i_cfg     (r_active[g]),
      .i_hdata   (io_bus.hdata),
      .i_vdata   (io_bus.vdata),
      .o_addr    (w_addr[g]),
      .o_hit     (w_hit[g])
    );
  end

  // Priority encoder: layer 0 is frontmost, so scan downward and let the lowest hit win.
  logic [SelW-1:0] w_sel;

  always_comb begin
    w_sel = '0;
    for (int i = int'(NLAYER) - 1; i >= 0; i--) begin
      if (w_hit[i]) w_sel = SelW'(i);
    end
  end

  assign io_bus.out_valid = r_s2_valid;
  assign io_bus.out_addr  = w_addr;
  assign io_bus.out_hit   = w_hit;
  assign io_bus.out_any   = |w_hit;
  assign io_bus.out_sel   = w_sel;

endmodule

// File: tb/tb_layer_addr_pipe.sv
module tb_layer_addr_pipe;
  import layer_pkg::*;

  localparam int NL     = 4;
  localparam int AW     = 15;
  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_addr_pipe_if bus ();

  layer_addr_pipe dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  typedef struct packed {
    logic                  vld;
    logic [NL-1:0][AW-1:0] addr;
    logic [NL-1:0]         hit;
    logic                  any;
    logic [1:0]            sel;
  } res_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Layer setup used for the backpressure stream.
  int t_hoff  [NL] = '{-8, 3, 0, 100};
  int t_voff  [NL] = '{0, -5, 0, 50};
  int t_shift [NL] = '{1, 0, 2, 3};
  int t_mirror[NL] = '{0, 1, 0, 1};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int l, input int en, input int hoff, input int voff,
                     input int shift, input int mirror, input int fs);
    bus.cfg_layer   = 2'(l);
    bus.cfg_en      = 1'(en);
    bus.cfg_hoff    = 12'(hoff);
    bus.cfg_voff    = 12'(voff);
    bus.cfg_shift   = 2'(shift);
    bus.cfg_mirror  = 1'(mirror);
    bus.cfg_we      = 1'b1;
    bus.frame_start = 1'(fs);
    tick();
    bus.cfg_we      = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic commit();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  // One coordinate through an otherwise idle pipe; result is on the outputs afterwards.
  task automatic send(input int h, input int v);
    bus.out_ready = 1'b1;
    bus.hdata     = 12'(h);
    bus.vdata     = 12'(v);
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic [3:0] hit, input int a0, input int a1,
                            input int a2, input int a3, input logic any, input int sel);
    chk({tag, " valid"}, 128'(bus.out_valid), 128'(1));
    chk({tag, " hit"},   128'(bus.out_hit), 128'(hit));
    chk({tag, " addr0"}, 128'(bus.out_addr[0]), 128'(a0));
    chk({tag, " addr1"}, 128'(bus.out_addr[1]), 128'(a1));
    chk({tag, " addr2"}, 128'(bus.out_addr[2]), 128'(a2));
    chk({tag, " addr3"}, 128'(bus.out_addr[3]), 128'(a3));
    chk({tag, " any"},   128'(bus.out_any), 128'(any));
    chk({tag, " sel"},   128'(bus.out_sel), 128'(sel));
  endtask

  function automatic res_t observe();
    res_t r;
    r.vld  = bus.out_valid;
    r.addr = bus.out_addr;
    r.hit  = bus.out_hit;
    r.any  = bus.out_any;
    r.sel  = bus.out_sel;
    return r;
  endfunction

  // Reference: integer arithmetic straight from the transform definition, all layers enabled.
  function automatic res_t model(input int h, input int v);
    res_t r = '0;
    r.vld = 1'b1;
    for (int i = 0; i < NL; i++) begin
      int sh = h + t_hoff[i];
      int sv = v + t_voff[i];
      int s  = (t_shift[i] > 3) ? 3 : t_shift[i];
      int tx;
      int ty;
      if (sh >= 0 && sv >= 0) begin
        tx = sh >> s;
        ty = sv >> s;
        if (tx < 160 && ty < 120) begin
          r.hit[i]  = 1'b1;
          r.addr[i] = AW'(ty * 160 + ((t_mirror[i] != 0) ? (159 - tx) : tx));
        end
      end
    end
    r.any = |r.hit;
    for (int i = NL - 1; i >= 0; i--) if (r.hit[i]) r.sel = 2'(i);
    return r;
  endfunction

  initial begin
    res_t q[$];
    res_t snap;
    res_t exp_r;
    logic stalled;
    logic acc;
    int   sent;
    int   rcvd;
    int   cyc;
    int   cur_h;
    int   cur_v;

    bus.frame_start = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_layer   = '0;
    bus.cfg_en      = 1'b0;
    bus.cfg_hoff    = '0;
    bus.cfg_voff    = '0;
    bus.cfg_shift   = '0;
    bus.cfg_mirror  = 1'b0;
    bus.in_valid    = 1'b0;
    bus.hdata       = '0;
    bus.vdata       = '0;
    bus.out_ready   = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst out_hit",   128'(bus.out_hit), 128'(0));
    chk("rst out_any",   128'(bus.out_any), 128'(0));
    chk("rst out_sel",   128'(bus.out_sel), 128'(0));
    chk("rst out_addr",  128'(bus.out_addr), 128'(0));
    chk("rst in_ready",  128'(bus.in_ready), 128'(1));

    // 1: shift 2, (4,8) -> tx 1, ty 2 -> 321
    cfg(0, 1, 0, 0, 2, 0, 0);
    commit();
    send(4, 8);
    expect_out("t1", 4'b0001, 321, 0, 0, 0, 1'b1, 0);

    // 2: negative sum is a miss, not a wrap
    cfg(0, 1, -8, 0, 2, 0, 0);
    commit();
    send(4, 0);
    expect_out("t2 neg", 4'b0000, 0, 0, 0, 0, 1'b0, 0);
    send(8, 0);
    expect_out("t2 zero", 4'b0001, 0, 0, 0, 0, 1'b1, 0);

    // 3: mirror, unit scale, image edges
    cfg(0, 1, 0, 0, 0, 1, 0);
    commit();
    send(0, 0);
    expect_out("t3 origin", 4'b0001, 159, 0, 0, 0, 1'b1, 0);
    send(159, 119);
    expect_out("t3 corner", 4'b0001, 19040, 0, 0, 0, 1'b1, 0);
    send(160, 0);
    expect_out("t3 right", 4'b0000, 0, 0, 0, 0, 1'b0, 0);

    // 4: shadow/active separation
    cfg(0, 1, 16, 0, 0, 0, 0);
    send(0, 0);
    expect_out("t4 no commit", 4'b0001, 159, 0, 0, 0, 1'b1, 0);
    commit();
    send(0, 0);
    expect_out("t4 committed", 4'b0001, 16, 0, 0, 0, 1'b1, 0);
    cfg(0, 1, 32, 0, 0, 0, 1);
    send(0, 0);
    expect_out("t4 coincident", 4'b0001, 16, 0, 0, 0, 1'b1, 0);
    commit();
    send(0, 0);
    expect_out("t4 next frame", 4'b0001, 32, 0, 0, 0, 1'b1, 0);

    // 5: priority select
    cfg(0, 0, 0, 0, 0, 0, 0);
    cfg(1, 1, 0, 0, 0, 0, 0);
    cfg(2, 1, 0, 0, 0, 0, 0);
    commit();
    send(5, 3);
    expect_out("t5 both", 4'b0110, 0, 485, 485, 0, 1'b1, 1);
    send(200, 0);
    expect_out("t5 none", 4'b0000, 0, 0, 0, 0, 1'b0, 0);
    cfg(1, 1, -10, 0, 0, 0, 0);
    commit();
    send(5, 3);
    expect_out("t5 back", 4'b0100, 0, 0, 485, 0, 1'b1, 2);

    // 6: random valid/ready stream against the reference model
    for (int i = 0; i < NL; i++) cfg(i, 1, t_hoff[i], t_voff[i], t_shift[i], t_mirror[i], 0);
    commit();
    stalled = 1'b0;
    snap    = '0;
    sent    = 0;
    rcvd    = 0;
    cyc     = 0;
    cur_h   = 0;
    cur_v   = 0;
    while ((sent < N_RAND || rcvd < N_RAND) && cyc < 20000) begin
      if (sent < N_RAND && !bus.in_valid && $urandom_range(3) != 0) begin
        cur_h        = int'($urandom_range(700));
        cur_v        = int'($urandom_range(520));
        bus.hdata    = 12'(cur_h);
        bus.vdata    = 12'(cur_v);
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (stalled) chk("stall hold", 128'(observe()), 128'(snap));
      if (bus.out_valid && bus.out_ready) begin
        chk("no extra output", 128'(q.size() > 0), 128'(1));
        if (q.size() > 0) begin
          exp_r = q.pop_front();
          chk($sformatf("stream #%0d", rcvd), 128'(observe()), 128'(exp_r));
          rcvd++;
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      snap    = observe();
      acc     = bus.in_valid && bus.in_ready;
      if (acc) begin
        q.push_back(model(cur_h, cur_v));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) bus.in_valid = 1'b0;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("stream received", 128'(rcvd), 128'(N_RAND));
    chk("stream leftover", 128'(q.size()), 128'(0));

    // Reset in the middle of traffic
    bus.out_ready = 1'b0;
    bus.hdata     = 12'(5);
    bus.vdata     = 12'(3);
    bus.in_valid  = 1'b1;
    tick();
    tick();
    chk("pre-rst out_valid", 128'(bus.out_valid), 128'(1));
    chk("pre-rst in_ready",  128'(bus.in_ready), 128'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid-rst in_ready",  128'(bus.in_ready), 128'(1));
    chk("mid-rst out_hit",   128'(bus.out_hit), 128'(0));
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post-rst out_valid", 128'(bus.out_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
